mvm_engine: RTL and testbench

MVM_ENGINE -- requirements
Module: mvm_engine

---
 rtl/mvm_pkg.sv | 17 +
 rtl/mvm_fifo.sv | 72 +++++++
 rtl/mvm_engine.sv | 215 +++++++++++++++++++++
 tb/tb_mvm_engine.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mvm_pkg.sv
// Shared types and helpers for the matrix-vector multiply engine.
// The accumulator saturation path is selected with the MVM_SATURATE_EN macro.
package mvm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_MAC,
        ST_DONE
    } state_t;

    // Width needed to hold acc + product without losing the carry used for clamping.
    function automatic int unsigned ACC_W(input int unsigned dw, input int unsigned out_w);
        return (((2 * dw) > out_w) ? (2 * dw) : out_w) + 1;
    endfunction

endpackage

// File: rtl/mvm_fifo.sv
// Operand buffer: synchronous FIFO with registered read data, full/empty flags,
// a synchronous flush and simultaneous push/pop.
module mvm_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             do_push, do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        do_pop   = pop_i && (cnt_q != '0) && !clr_i;
        // A pop in the same cycle frees the slot, so a full buffer can still accept data.
        do_push  = push_i && ((cnt_q != CW'(DEPTH)) || do_pop) && !clr_i;
        wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        cnt_d    = cnt_q + CW'(do_push) - CW'(do_pop);
        dout_d   = do_pop ? mem_q[rd_ptr_q] : dout_q;
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
            dout_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            dout_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            dout_q   <= dout_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign data_o  = dout_q;
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/mvm_engine.sv
// Matrix-vector multiply engine: buffers A rows and vector B, then MACs c = A*B.
// Define MVM_SATURATE_EN to clamp accumulators and report ovf instead of wrapping.
module mvm_engine
    import mvm_pkg::*;
#(
    parameter int unsigned ROWS  = 8,
    parameter int unsigned COLS  = 8,
    parameter int unsigned DW    = 8,
    parameter int unsigned OUT_W = 24
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      clr,
    input  logic                      wr_en,
    input  logic [$clog2(ROWS+1)-1:0] wr_sel,
    input  logic [DW-1:0]             wr_data,
    output logic [ROWS:0]             full,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    output logic                      ovf,
    output logic [ROWS*OUT_W-1:0]     c
);

    localparam int unsigned SEL_W  = $clog2(ROWS + 1);
    localparam int unsigned CNT_W  = $clog2(COLS + 1);
    localparam int unsigned PROD_W = 2 * DW;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [OUT_W-1:0]  acc_q [ROWS];
    logic [OUT_W-1:0]  acc_d [ROWS];
    logic [OUT_W-1:0]  c_q   [ROWS];
    logic [OUT_W-1:0]  c_d   [ROWS];
    logic              err_q, err_d;
    logic [ROWS:0]     push, buf_empty;
    logic [DW-1:0]     buf_dout [ROWS+1];
    logic              pop_all, buf_clr;
    logic              start_job, add_en, last_mac;
    logic              sel_full, sel_valid, wr_ok;
    logic [PROD_W-1:0] prod;

    genvar g;
    generate
        for (g = 0; g <= ROWS; g++) begin : g_buf
            mvm_fifo #(
                .DEPTH(COLS),
                .WIDTH(DW)
            ) u_fifo (
                .clk    (clk),
                .rst_n  (rst_n),
                .clr_i  (buf_clr),
                .push_i (push[g]),
                .pop_i  (pop_all),
                .data_i (wr_data),
                .data_o (buf_dout[g]),
                .full_o (full[g]),
                .empty_o(buf_empty[g])
            );
        end
    endgenerate

    // MAC pops for COLS cycles; FIFO read data lags a cycle, so adds run at cnt 1..COLS.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        buf_clr   = 1'b0;
        pop_all   = 1'b0;
        start_job = 1'b0;
        add_en    = 1'b0;
        last_mac  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_LOAD;
                    buf_clr   = 1'b1;
                    start_job = 1'b1;
                end
            end
            ST_LOAD: begin
                cnt_d = '0;
                if (&full) begin
                    state_d = ST_MAC;
                end
            end
            ST_MAC: begin
                pop_all = (cnt_q < CNT_W'(COLS)) && !(|buf_empty);
                add_en  = (cnt_q != '0);
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(COLS)) begin
                    last_mac = 1'b1;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (clr) begin
            state_d   = ST_IDLE;
            cnt_d     = '0;
            buf_clr   = 1'b1;
            pop_all   = 1'b0;
            start_job = 1'b0;
            add_en    = 1'b0;
            last_mac  = 1'b0;
        end
    end

    always_comb begin
        sel_full  = 1'b0;
        push      = '0;
        sel_valid = (wr_sel <= SEL_W'(ROWS));
        for (int unsigned i = 0; i <= ROWS; i++) begin
            if (wr_sel == SEL_W'(i)) sel_full = full[i];
        end
        wr_ok = wr_en && !clr && (state_q == ST_LOAD) && sel_valid && !sel_full;
        for (int unsigned i = 0; i <= ROWS; i++) begin
            push[i] = wr_ok && (wr_sel == SEL_W'(i));
        end
        err_d = start_job ? 1'b0 : err_q;
        if (wr_en && !clr && !wr_ok) err_d = 1'b1;
    end

`ifdef MVM_SATURATE_EN
    localparam int unsigned SUM_W = ACC_W(DW, OUT_W);
    logic             ovf_q, ovf_d;
    logic [SUM_W-1:0] sum;
`endif

    always_comb begin
        prod = '0;
        for (int unsigned r = 0; r < ROWS; r++) begin
            acc_d[r] = acc_q[r];
            c_d[r]   = c_q[r];
        end
`ifdef MVM_SATURATE_EN
        ovf_d = ovf_q;
        sum   = '0;
`endif
        if (start_job) begin
            for (int unsigned r = 0; r < ROWS; r++) acc_d[r] = '0;
`ifdef MVM_SATURATE_EN
            ovf_d = 1'b0;
`endif
        end
        if (add_en) begin
            for (int unsigned r = 0; r < ROWS; r++) begin
                prod = PROD_W'(buf_dout[r]) * PROD_W'(buf_dout[ROWS]);
`ifdef MVM_SATURATE_EN
                sum = SUM_W'(acc_q[r]) + SUM_W'(prod);
                if (sum[SUM_W-1:OUT_W] != '0) begin
                    acc_d[r] = '1;
                    ovf_d    = 1'b1;
                end else begin
                    acc_d[r] = sum[OUT_W-1:0];
                end
`else
                acc_d[r] = acc_q[r] + OUT_W'(prod);
`endif
            end
        end
        // Results publish on the DONE entry edge so c is valid while done is high.
        if (last_mac) begin
            for (int unsigned r = 0; r < ROWS; r++) c_d[r] = acc_d[r];
        end
        if (clr) begin
            for (int unsigned r = 0; r < ROWS; r++) begin
                acc_d[r] = '0;
                c_d[r]   = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            for (int unsigned r = 0; r < ROWS; r++) begin
                acc_q[r] <= '0;
                c_q[r]   <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            for (int unsigned r = 0; r < ROWS; r++) begin
                acc_q[r] <= acc_d[r];
                c_q[r]   <= c_d[r];
            end
        end
    end

`ifdef MVM_SATURATE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ovf_q <= 1'b0;
        else        ovf_q <= ovf_d;
    end
    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

    always_comb begin
        for (int unsigned r = 0; r < ROWS; r++) begin
            c[r*OUT_W +: OUT_W] = c_q[r];
        end
    end

    assign busy = (state_q == ST_LOAD) || (state_q == ST_MAC);
    assign done = (state_q == ST_DONE);
    assign err  = err_q;

endmodule

// File: tb/tb_mvm_engine.sv
// Directed self-checking bench for mvm_engine (8x8, DW=8) with OUT_W=24 and OUT_W=16 copies.
module tb_mvm_engine;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        clr;
    logic        wr_en;
    logic [3:0]  wr_sel;
    logic [7:0]  wr_data;
    logic [8:0]  full24, full16;
    logic        busy24, busy16, done24, done16, err24, err16, ovf24, ovf16;
    logic [191:0] c24;
    logic [127:0] c16;

    int checks;
    int errors;

    logic [7:0] a_m [8][8];
    logic [7:0] b_v [8];

    mvm_engine #(.ROWS(8), .COLS(8), .DW(8), .OUT_W(24)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .clr(clr), .wr_en(wr_en),
        .wr_sel(wr_sel), .wr_data(wr_data), .full(full24), .busy(busy24),
        .done(done24), .err(err24), .ovf(ovf24), .c(c24)
    );

    mvm_engine #(.ROWS(8), .COLS(8), .DW(8), .OUT_W(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start), .clr(clr), .wr_en(wr_en),
        .wr_sel(wr_sel), .wr_data(wr_data), .full(full16), .busy(busy16),
        .done(done16), .err(err16), .ovf(ovf16), .c(c16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [23:0] get_c24(input int r);
        return c24[r*24 +: 24];
    endfunction

    function automatic logic [15:0] get_c16(input int r);
        return c16[r*16 +: 16];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic write(input int sel, input int d);
        wr_en   = 1'b1;
        wr_sel  = 4'(sel);
        wr_data = 8'(d);
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic load_job();
        for (int r = 0; r < 8; r++)
            for (int k = 0; k < 8; k++) write(r, int'(a_m[r][k]));
        for (int k = 0; k < 8; k++) write(8, int'(b_v[k]));
    endtask

    task automatic set_ones();
        for (int r = 0; r < 8; r++) begin
            b_v[r] = 8'd1;
            for (int k = 0; k < 8; k++) a_m[r][k] = 8'd1;
        end
    endtask

    task automatic set_ramp();
        for (int r = 0; r < 8; r++) begin
            b_v[r] = 8'(r);
            for (int k = 0; k < 8; k++) a_m[r][k] = 8'(r + 1);
        end
    endtask

    // Bounded watch: latency (ticks to first done) and number of done cycles.
    task automatic run_to_done(input int budget, output int lat, output int pulses);
        lat    = -1;
        pulses = 0;
        for (int i = 1; i <= budget; i++) begin
            tick();
            if (done24) begin
                pulses++;
                if (lat < 0) lat = i;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; clr = 1'b0; wr_en = 1'b0; wr_sel = '0; wr_data = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy24, done24, err24, ovf24} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: busy/done/err/ovf=%b expected 0000", {busy24, done24, err24, ovf24});
        end
        checks++;
        if (full24 !== 9'h000) begin
            errors++;
            $display("FAIL reset_full: got %h expected 000", full24);
        end
        checks++;
        if (c24 !== '0) begin
            errors++;
            $display("FAIL reset_c: got %h expected 0", c24);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (busy24 !== 1'b0 || done24 !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: busy=%b done=%b expected 0 0", busy24, done24);
        end
    endtask

    task automatic test_ones();
        int lat, pulses;
        set_ones();
        do_start();
        checks++;
        if (busy24 !== 1'b1 || full24 !== 9'h000 || err24 !== 1'b0) begin
            errors++;
            $display("FAIL ones_load_entry: busy=%b full=%h err=%b expected 1 000 0", busy24, full24, err24);
        end
        load_job();
        checks++;
        if (full24 !== 9'h1FF) begin
            errors++;
            $display("FAIL ones_full: got %h expected 1ff", full24);
        end
        run_to_done(20, lat, pulses);
        // MAC entry is one tick after full is seen; done follows 9 cycles later.
        checks++;
        if (lat !== 10 || pulses !== 1) begin
            errors++;
            $display("FAIL ones_done_timing: lat=%0d pulses=%0d expected 10 1", lat, pulses);
        end
        for (int r = 0; r < 8; r++) begin
            checks++;
            if (get_c24(r) !== 24'd8) begin
                errors++;
                $display("FAIL ones_c%0d: got %0d expected 8", r, get_c24(r));
            end
        end
        checks++;
        if (busy24 !== 1'b0 || err24 !== 1'b0) begin
            errors++;
            $display("FAIL ones_end_flags: busy=%b err=%b expected 0 0", busy24, err24);
        end
    endtask

    task automatic test_ramp();
        int lat, pulses;
        set_ramp();
        do_start();
        load_job();
        run_to_done(20, lat, pulses);
        checks++;
        if (lat !== 10 || pulses !== 1) begin
            errors++;
            $display("FAIL ramp_done_timing: lat=%0d pulses=%0d expected 10 1", lat, pulses);
        end
        for (int r = 0; r < 8; r++) begin
            checks++;
            if (get_c24(r) !== 24'(28 * (r + 1))) begin
                errors++;
                $display("FAIL ramp_c%0d: got %0d expected %0d", r, get_c24(r), 28 * (r + 1));
            end
        end
    endtask

    task automatic test_wide();
        int lat, pulses;
        logic [15:0] exp16;
        logic        exp_ovf;
`ifdef MVM_SATURATE_EN
        exp16 = 16'd65535; exp_ovf = 1'b1;
`else
        exp16 = 16'd61448; exp_ovf = 1'b0;
`endif
        for (int r = 0; r < 8; r++) begin
            b_v[r] = 8'd255;
            for (int k = 0; k < 8; k++) a_m[r][k] = 8'd255;
        end
        do_start();
        load_job();
        run_to_done(20, lat, pulses);
        for (int r = 0; r < 8; r++) begin
            checks++;
            if (get_c24(r) !== 24'd520200) begin
                errors++;
                $display("FAIL wide24_c%0d: got %0d expected 520200", r, get_c24(r));
            end
            checks++;
            if (get_c16(r) !== exp16) begin
                errors++;
                $display("FAIL wide16_c%0d: got %0d expected %0d", r, get_c16(r), exp16);
            end
        end
        checks++;
        if (ovf24 !== 1'b0) begin
            errors++;
            $display("FAIL wide24_ovf: got %b expected 0", ovf24);
        end
        checks++;
        if (ovf16 !== exp_ovf) begin
            errors++;
            $display("FAIL wide16_ovf: got %b expected %b", ovf16, exp_ovf);
        end
        checks++;
        if (busy16 !== 1'b0 || done16 !== 1'b0 || err16 !== 1'b0 || full16 !== 9'h000) begin
            errors++;
            $display("FAIL wide16_flags: busy=%b done=%b err=%b full=%h expected 0 0 0 000",
                     busy16, done16, err16, full16);
        end
    endtask

    task automatic test_write_errors();
        int lat, pulses;
        write(0, 5);
        checks++;
        if (err24 !== 1'b1) begin
            errors++;
            $display("FAIL err_idle_write: got %b expected 1", err24);
        end
        set_ramp();
        do_start();
        checks++;
        if (err24 !== 1'b0) begin
            errors++;
            $display("FAIL err_cleared_by_start: got %b expected 0", err24);
        end
        for (int k = 0; k < 8; k++) write(3, int'(a_m[3][k]));
        write(3, 200);
        checks++;
        if (err24 !== 1'b1 || full24[3] !== 1'b1) begin
            errors++;
            $display("FAIL err_ninth_write: err=%b full3=%b expected 1 1", err24, full24[3]);
        end
        for (int r = 0; r < 8; r++)
            if (r != 3)
                for (int k = 0; k < 8; k++) write(r, int'(a_m[r][k]));
        for (int k = 0; k < 8; k++) write(8, int'(b_v[k]));
        run_to_done(20, lat, pulses);
        checks++;
        if (lat !== 10 || pulses !== 1) begin
            errors++;
            $display("FAIL err_job_done: lat=%0d pulses=%0d expected 10 1", lat, pulses);
        end
        for (int r = 0; r < 8; r++) begin
            checks++;
            if (get_c24(r) !== 24'(28 * (r + 1))) begin
                errors++;
                $display("FAIL err_job_c%0d: got %0d expected %0d", r, get_c24(r), 28 * (r + 1));
            end
        end
        checks++;
        if (err24 !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky: got %b expected 1", err24);
        end
        do_start();
        write(9, 7);
        checks++;
        if (err24 !== 1'b1 || full24 !== 9'h000) begin
            errors++;
            $display("FAIL err_bad_sel: err=%b full=%h expected 1 000", err24, full24);
        end
        write(8, 1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        checks++;
        if (busy24 !== 1'b0 || full24 !== 9'h000 || get_c24(0) !== 24'd0) begin
            errors++;
            $display("FAIL err_clr_abort: busy=%b full=%h c0=%0d expected 0 000 0",
                     busy24, full24, get_c24(0));
        end
    endtask

    task automatic test_start_in_mac();
        int lat, pulses;
        set_ramp();
        do_start();
        load_job();
        repeat (3) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        run_to_done(25, lat, pulses);
        checks++;
        if (lat !== 6 || pulses !== 1) begin
            errors++;
            $display("FAIL start_in_mac_done: lat=%0d pulses=%0d expected 6 1", lat, pulses);
        end
        checks++;
        if (get_c24(7) !== 24'd224 || get_c24(0) !== 24'd28) begin
            errors++;
            $display("FAIL start_in_mac_c: c7=%0d c0=%0d expected 224 28", get_c24(7), get_c24(0));
        end
        checks++;
        if (busy24 !== 1'b0) begin
            errors++;
            $display("FAIL start_in_mac_idle: busy=%b expected 0", busy24);
        end
    endtask

    task automatic test_clr_mac();
        int lat, pulses;
        set_ones();
        do_start();
        load_job();
        tick();
        repeat (4) tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        checks++;
        if (busy24 !== 1'b0 || done24 !== 1'b0 || full24 !== 9'h000) begin
            errors++;
            $display("FAIL clr_state: busy=%b done=%b full=%h expected 0 0 000", busy24, done24, full24);
        end
        for (int r = 0; r < 8; r++) begin
            checks++;
            if (get_c24(r) !== 24'd0) begin
                errors++;
                $display("FAIL clr_c%0d: got %0d expected 0", r, get_c24(r));
            end
        end
        run_to_done(20, lat, pulses);
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("FAIL clr_no_done: pulses=%0d expected 0", pulses);
        end
        do_start();
        load_job();
        run_to_done(20, lat, pulses);
        checks++;
        if (lat !== 10 || pulses !== 1 || get_c24(5) !== 24'd8) begin
            errors++;
            $display("FAIL clr_next_job: lat=%0d pulses=%0d c5=%0d expected 10 1 8", lat, pulses, get_c24(5));
        end
    endtask

    task automatic test_reset_mid();
        int lat, pulses;
        set_ramp();
        do_start();
        for (int k = 0; k < 8; k++) write(0, int'(a_m[0][k]));
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (busy24 !== 1'b0 || full24 !== 9'h000 || c24 !== '0 || err24 !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_load: busy=%b full=%h err=%b expected 0 000 0", busy24, full24, err24);
        end
        #2 rst_n = 1'b1;
        run_to_done(20, lat, pulses);
        checks++;
        if (pulses !== 0 || busy24 !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_load_quiet: pulses=%0d busy=%b expected 0 0", pulses, busy24);
        end
        do_start();
        load_job();
        repeat (3) tick();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (busy24 !== 1'b0 || full24 !== 9'h000 || done24 !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_mac: busy=%b full=%h done=%b expected 0 000 0", busy24, full24, done24);
        end
        #2 rst_n = 1'b1;
        run_to_done(20, lat, pulses);
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("FAIL rst_mid_mac_quiet: pulses=%0d expected 0", pulses);
        end
        set_ones();
        do_start();
        load_job();
        run_to_done(20, lat, pulses);
        checks++;
        if (lat !== 10 || get_c24(2) !== 24'd8) begin
            errors++;
            $display("FAIL rst_recover_job: lat=%0d c2=%0d expected 10 8", lat, get_c24(2));
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_ones();
        test_ramp();
        test_wide();
        test_write_errors();
        test_start_in_mac();
        test_clr_mac();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
